// File: rtl/pq_pkg.sv
// Shared types and helpers for the hardware priority queue family and its clients.
package pq_pkg;

  localparam int PQ_CAPACITY = 255;
  localparam int KW          = 8;
  localparam int VW          = 8;
  localparam logic [KW-1:0] KEYINF = '1;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] value;
  } kv_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } pq_client_state_t;

  function automatic logic cmp_kv_gt(input kv_t a, input kv_t b);
    return a.key > b.key;
  endfunction

  // KEYINF marks an empty slot inside the PQ, so it can never be stored as data.
  function automatic logic is_sentinel(input kv_t kv);
    return kv.key == KEYINF;
  endfunction

endpackage

// File: rtl/pq_batch_sorter_out_reg.sv
// Single-entry valid/ready output register carrying one kv_t item and its last flag.
module pq_out_reg
  import pq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  kv_t  load_kv,
  input  logic load_last,
  input  logic ready,
  output logic valid,
  output kv_t  kv,
  output logic last,
  output logic can_load
);

  assign can_load = !valid || ready;

  // A load always wins over a consume so back-to-back items stream at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      kv    <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      kv    <= load_kv;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pq_batch_sorter.sv
// Batch client for a HWPQ: enqueue a batch of items, then drain the queue in priority order.
module pq_batch_sorter
  import pq_pkg::*;
#(
  parameter int CAP = PQ_CAPACITY,
  parameter int CW  = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  kv_t           in_kv,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output kv_t           out_kv,
  output logic          out_last,
  output logic          pq_enq,
  output logic          pq_deq,
  output kv_t           pq_kvi,
  input  kv_t           pq_kvo,
  input  logic          pq_full,
  input  logic          pq_empty,
  input  logic          pq_busy,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          bad_key
);

  pq_client_state_t state, state_next;
  logic [CW-1:0]    count_next;
  logic             accept;
  logic             ovf_set;
  logic             bad_set;
  logic             can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      count   <= '0;
      ovf     <= 1'b0;
      bad_key <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ovf     <= ovf | ovf_set;
      bad_key <= bad_key | bad_set;
    end
  end

  // The count guard keeps the tracked occupancy bounded even if pq_full lags.
  always_comb begin
    state_next = state;
    count_next = count;
    in_ready   = 1'b0;
    accept     = 1'b0;
    pq_enq     = 1'b0;
    pq_deq     = 1'b0;
    pq_kvi     = '0;
    ovf_set    = 1'b0;
    bad_set    = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = !pq_busy && !pq_full && (count != CW'(CAP));
        accept   = in_valid && in_ready;
        if (accept) begin
          if (is_sentinel(in_kv)) begin
            bad_set = 1'b1;
          end else begin
            pq_enq     = 1'b1;
            pq_kvi     = in_kv;
            count_next = count + CW'(1);
          end
          if (in_last && (count_next != '0)) begin
            state_next = DRAIN;
          end
        end else if (pq_full && (count != '0)) begin
          state_next = DRAIN;
          ovf_set    = 1'b1;
        end
      end
      DRAIN: begin
        pq_deq = !pq_busy && !pq_empty && can_load && (count != '0);
        if (pq_deq) begin
          count_next = count - CW'(1);
          if (count == CW'(1)) begin
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  pq_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pq_deq),
    .load_kv   (pq_kvo),
    .load_last (count == CW'(1)),
    .ready     (out_ready),
    .valid     (out_valid),
    .kv        (out_kv),
    .last      (out_last),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_pq_batch_sorter.sv
// Directed bench for pq_batch_sorter against a behavioural MIN_PQ model.
module tb_pq_batch_sorter;
  import pq_pkg::*;

  localparam int CAP = PQ_CAPACITY;
  localparam int CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  kv_t           in_kv;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  kv_t           out_kv;
  logic          out_last;
  logic          pq_enq;
  logic          pq_deq;
  kv_t           pq_kvi;
  kv_t           pq_kvo;
  logic          pq_full;
  logic          pq_empty;
  logic          pq_busy;
  logic [CW-1:0] count;
  logic          ovf;
  logic          bad_key;

  typedef struct {
    logic [7:0] in_key;
    logic [7:0] in_val;
    logic       in_last;
    logic [7:0] exp_key;
    logic [7:0] exp_val;
    logic       exp_last;
  } vec_t;

  typedef struct packed {
    kv_t  kv;
    logic last;
  } out_t;

  vec_t  vecs [4];
  out_t  got [$];
  int    total = 0;
  int    bad = 0;
  int    proto_err = 0;
  int    ready_mode = 0;
  logic  busy_force = 1'b0;
  logic  prev_stall;
  out_t  prev_out;

  always #5 clk = ~clk;

  pq_batch_sorter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kv     (in_kv),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kv    (out_kv),
    .out_last  (out_last),
    .pq_enq    (pq_enq),
    .pq_deq    (pq_deq),
    .pq_kvi    (pq_kvi),
    .pq_kvo    (pq_kvo),
    .pq_full   (pq_full),
    .pq_empty  (pq_empty),
    .pq_busy   (pq_busy),
    .count     (count),
    .ovf       (ovf),
    .bad_key   (bad_key)
  );

  // Behavioural MIN_PQ: unordered storage, head is the smallest key.
  kv_t mem [CAP];
  int  n = 0;

  function automatic int min_idx();
    int best = 0;
    for (int i = 1; i < CAP; i++)
      if (i < n && cmp_kv_gt(mem[best], mem[i])) best = i;
    return best;
  endfunction

  always_comb begin
    pq_kvo = '0;
    if (n > 0) pq_kvo = mem[min_idx()];
  end

  assign pq_empty = (n == 0);
  assign pq_full  = (n == CAP);
  assign pq_busy  = busy_force;

  always @(posedge clk) begin
    if (rst) begin
      n <= 0;
    end else if (pq_enq && !pq_busy && n < CAP) begin
      mem[n] <= pq_kvi;
      n      <= n + 1;
    end else if (pq_deq && !pq_busy && n > 0) begin
      mem[min_idx()] <= mem[n-1];
      n              <= n - 1;
    end
  end

  // Protocol monitor and output collector, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      proto_err <= proto_err
                 + int'(pq_enq && pq_deq)
                 + int'((pq_enq || pq_deq) && pq_busy)
                 + int'(pq_deq && out_valid && !out_ready)
                 + int'(prev_stall && (!out_valid || out_kv != prev_out.kv || out_last != prev_out.last))
                 + int'(int'(count) > CAP);
      prev_stall <= out_valid && !out_ready;
      prev_out   <= '{kv: out_kv, last: out_last};
      if (out_valid && out_ready) got.push_back('{kv: out_kv, last: out_last});
    end
  end

  // Consumer: always ready, or the stall pattern 1,0,0,1 repeating.
  initial begin
    int idx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      idx++;
      if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = (idx % 4 == 0) || (idx % 4 == 3);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic [7:0] val, input logic last);
    bit ok = 0;
    in_valid = 1'b1;
    in_kv    = '{key: key, value: val};
    in_last  = last;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic wait_outputs(input int num, input int budget);
    for (int c = 0; c < budget && got.size() < num; c++) @(posedge clk);
    #1;
    if (got.size() < num) checkOutput("out_timeout", got.size(), num);
  endtask

  function automatic int got_key(input int i);
    return (i < got.size()) ? int'(got[i].kv.key) : -1;
  endfunction

  function automatic int got_val(input int i);
    return (i < got.size()) ? int'(got[i].kv.value) : -1;
  endfunction

  function automatic int got_last(input int i);
    return (i < got.size()) ? int'(got[i].last) : -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic run_table(input string tag);
    got.delete();
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i].in_key, vecs[i].in_val, vecs[i].in_last);
    wait_outputs(4, 200);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_key%0d", tag, i), got_key(i), int'(vecs[i].exp_key));
      checkOutput($sformatf("%s_val%0d", tag, i), got_val(i), int'(vecs[i].exp_val));
      checkOutput($sformatf("%s_last%0d", tag, i), got_last(i), int'(vecs[i].exp_last));
    end
    checkOutput({tag, "_count"}, got.size(), 4);
    checkOutput({tag, "_cnt_zero"}, int'(count), 0);
    checkOutput({tag, "_state"}, int'(dut.state), int'(FILL));
  endtask

  initial begin
    int   keys [257];
    int   q1 [$];
    int   q2 [$];
    int   mism;
    int   last_err;

    vecs[0] = '{8'd5, 8'd0, 1'b0, 8'd1, 8'd3, 1'b0};
    vecs[1] = '{8'd3, 8'd1, 1'b0, 8'd3, 8'd1, 1'b0};
    vecs[2] = '{8'd9, 8'd2, 1'b0, 8'd5, 8'd0, 1'b0};
    vecs[3] = '{8'd1, 8'd3, 1'b1, 8'd9, 8'd2, 1'b1};

    in_valid = 1'b0;
    in_kv    = '0;
    in_last  = 1'b0;
    rst      = 1'b1;
    repeat (3) tick();
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_bad_key", int'(bad_key), 0);
    checkOutput("rst_strobes", int'({pq_enq, pq_deq, out_last}), 0);
    checkOutput("rst_state", int'(dut.state), int'(FILL));
    rst = 1'b0;
    tick();

    $display("[TB] min-pq batch");
    run_table("mq");

    $display("[TB] backpressure batch");
    ready_mode = 1;
    run_table("bp");
    ready_mode = 0;
    repeat (2) tick();

    $display("[TB] sentinel batch");
    do_reset();
    applyStimulus(8'd4, 8'd0, 1'b0);
    applyStimulus(8'd255, 8'd1, 1'b0);
    applyStimulus(8'd2, 8'd2, 1'b1);
    wait_outputs(2, 100);
    repeat (4) tick();
    checkOutput("sent_count", got.size(), 2);
    checkOutput("sent_key0", got_key(0), 2);
    checkOutput("sent_key1", got_key(1), 4);
    checkOutput("sent_last1", got_last(1), 1);
    checkOutput("sent_bad_key", int'(bad_key), 1);
    got.delete();
    applyStimulus(8'd255, 8'd7, 1'b1);
    repeat (6) tick();
    checkOutput("sent_single_none", got.size(), 0);
    checkOutput("sent_single_state", int'(dut.state), int'(FILL));
    checkOutput("sent_single_cnt", int'(count), 0);

    $display("[TB] busy pq");
    do_reset();
    applyStimulus(8'd8, 8'd0, 1'b0);
    applyStimulus(8'd2, 8'd1, 1'b0);
    busy_force = 1'b1;
    in_valid   = 1'b1;
    in_kv      = '{key: 8'd6, value: 8'd2};
    repeat (3) begin
      @(negedge clk);
      checkOutput("busy_fill", int'({in_ready, pq_enq}), 0);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    busy_force = 1'b0;
    applyStimulus(8'd6, 8'd2, 1'b0);
    applyStimulus(8'd4, 8'd3, 1'b1);
    busy_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("busy_drain", int'({pq_deq, out_valid}), 0);
    end
    @(posedge clk);
    #1;
    busy_force = 1'b0;
    wait_outputs(4, 100);
    checkOutput("busy_key0", got_key(0), 2);
    checkOutput("busy_key1", got_key(1), 4);
    checkOutput("busy_key2", got_key(2), 6);
    checkOutput("busy_key3", got_key(3), 8);

    $display("[TB] overflow batch");
    do_reset();
    for (int i = 0; i < 257; i++) keys[i] = int'($urandom_range(0, 254));
    for (int i = 0; i < 257; i++) applyStimulus(8'(keys[i]), 8'(i), i == 256);
    wait_outputs(257, 3000);
    repeat (3) tick();
    for (int i = 0; i < 255; i++) q1.push_back(keys[i]);
    q2.push_back(keys[255]);
    q2.push_back(keys[256]);
    q1.sort();
    q2.sort();
    mism = 0;
    last_err = 0;
    for (int i = 0; i < 257; i++) begin
      if (got_key(i) != ((i < 255) ? q1[i] : q2[i-255])) mism++;
      if (got_last(i) != int'(i == 254 || i == 256)) last_err++;
    end
    checkOutput("ovf_flag", int'(ovf), 1);
    checkOutput("ovf_total", got.size(), 257);
    checkOutput("ovf_order", mism, 0);
    checkOutput("ovf_last_marks", last_err, 0);
    checkOutput("ovf_cnt_zero", int'(count), 0);

    $display("[TB] reset mid-drain");
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i].in_key, vecs[i].in_val, vecs[i].in_last);
    for (int c = 0; c < 100 && got.size() < 2; c++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("mid_progress", (got.size() >= 2) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_out_valid", int'(out_valid), 0);
    checkOutput("mid_out_last", int'(out_last), 0);
    checkOutput("mid_count", int'(count), 0);
    checkOutput("mid_state", int'(dut.state), int'(FILL));
    checkOutput("mid_deq", int'(pq_deq), 0);
    rst = 1'b0;
    got.delete();
    applyStimulus(8'd7, 8'd0, 1'b0);
    applyStimulus(8'd6, 8'd1, 1'b1);
    wait_outputs(2, 100);
    repeat (3) tick();
    checkOutput("mid_new_count", got.size(), 2);
    checkOutput("mid_new_key0", got_key(0), 6);
    checkOutput("mid_new_val0", got_val(0), 1);
    checkOutput("mid_new_key1", got_key(1), 7);
    checkOutput("mid_new_last1", got_last(1), 1);

    checkOutput("protocol", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pq_batch_sorter.md
# pq_batch_sorter

Initiator-side client for any HWPQ implementation that uses the standard pq_pkg interface. It accepts a batch of kv_t items on a valid/ready input stream and enqueues each one into an attached priority queue. At the end of the batch it dequeues the queue completely and emits the items on a valid/ready output stream in priority order (ascending key for MIN_PQ, descending for MAX_PQ). It sits between a streaming producer/consumer and a pq instance, and also serves as the standard traffic generator for HWPQ benches.

## Interface
Parameters:
- CAP, default pq_pkg::PQ_CAPACITY (255): capacity of the attached PQ.
- CW, default $clog2(CAP+1) (8): width of the occupancy counter.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input item valid
- in_ready  out  1  block accepts the input item this cycle
- in_kv  in  kv_t  input item
- in_last  in  1  marks the final item of a batch (qualified by in_valid)
- out_valid  out  1  output register holds an item
- out_ready  in  1  consumer accepts out_kv
- out_kv  out  kv_t  sorted output item (registered)
- out_last  out  1  final item of the current drain
- pq_enq  out  1  enqueue strobe to the PQ
- pq_deq  out  1  dequeue strobe to the PQ
- pq_kvi  out  kv_t  item to enqueue
- pq_kvo  in  kv_t  current PQ head (valid when !pq_empty)
- pq_full  in  1  PQ holds CAP items
- pq_empty  in  1  PQ holds no items
- pq_busy  in  1  PQ cannot take enq/deq this cycle
- count  out  CW  items currently held in the PQ, as tracked by this block
- ovf  out  1  sticky: a batch was split because the PQ filled
- bad_key  out  1  sticky: an input item with key == KEYINF was dropped

## Operation
- FSM states: FILL (reset state) and DRAIN.
- Reset values: all outputs 0, count 0, state FILL. rst is shared with the PQ, so the PQ empties on the same edge. Reset mid-batch discards all held items and any pending output.
- FILL:
  - in_ready = !pq_busy && !pq_full.
  - On an accept (in_valid && in_ready) with in_kv.key != KEYINF: pq_enq = 1, pq_kvi = in_kv, count += 1.
  - On an accept with key == KEYINF: no enqueue, set bad_key, count unchanged.
  - Accept with in_last: go to DRAIN if the post-accept count > 0. Otherwise stay in FILL with no output (empty batch).
  - pq_full asserted in FILL with count > 0: go to DRAIN without in_last, set ovf (early drain). After the drain, return to FILL and continue the same batch.
- DRAIN:
  - in_ready = 0.
  - Dequeue condition: pq_deq = !pq_busy && !pq_empty && (!out_valid || out_ready).
  - On pq_deq: out_kv <= pq_kvo, out_valid <= 1, out_last <= (count == 1), count -= 1.
  - out_valid clears on out_ready when no new deq occurs in the same cycle.
  - When the deq with count == 1 happens, state returns to FILL on the next edge. The output register may still be draining at that point; FILL input acceptance proceeds in parallel.
- pq_enq and pq_deq are never asserted in the same cycle, and neither is asserted while pq_busy.
- count never exceeds CAP and never underflows. If pq_empty is seen with count != 0 in DRAIN, the block still does not deq.
- ovf and bad_key clear only on rst.

## Timing
- Input accept to pq_enq: same cycle (combinational strobe, registered count).
- pq_deq at cycle t produces out_valid with out_kv at cycle t+1.
- Throughput is 1 item/cycle in each direction while the PQ is not busy and out_ready is held high.
- out_valid/out_kv/out_last hold stable while out_valid && !out_ready.
- A batch's first output appears no earlier than 2 cycles after its in_last accept: the DRAIN entry edge, then the deq.

## Structure
- Put the following in pq_pkg: a pq_client_state_t enum {FILL, DRAIN}, and a helper function is_sentinel(kv_t) that compares against KEYINF.
- Use the existing kv_t, KEYINF and cmp_kv_gt from pq_pkg; no new widths.
- One sub-module: pq_out_reg, a single-entry valid/ready output register carrying kv_t plus a last bit.

## Test plan
- MIN_PQ: keys 5,3,9,1 (values 0..3), in_last on key 1 -> output keys 1,3,5,9 with values 3,1,0,2; out_last only on key 9; count returns to 0.
- Backpressure: same batch with out_ready toggling 1,0,0,1,… -> out_kv stable while stalled, no lost or duplicated items, pq_deq never asserted while out_valid && !out_ready.
- Overflow: 257 items of random keys with CAP=255 -> ovf set, first drain emits 255 sorted items ending with out_last, then the remaining 2 items are emitted sorted with a second out_last.
- Sentinel: batch 4, KEYINF(255), 2 with in_last on 2 -> bad_key=1, output keys 2,4 only; a single-item batch of key 255 -> no output, state stays FILL.
- Busy PQ: hold pq_busy=1 for 3 cycles mid-fill and mid-drain -> in_ready=0, pq_enq=pq_deq=0 throughout, order preserved afterward.
- Reset mid-drain: rst after 2 of 4 outputs -> next cycle all outputs 0, count 0, state FILL; a new batch 7,6 sorts to 6,7.
